// File: rtl/siso_frame_pkg.sv
// Shared types and sizing helpers for the serial frame controller.
package siso_frame_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Counter must reach WIDTH+DEPTH, the total number of shift edges per word.
    function automatic int unsigned cnt_width(input int unsigned width, input int unsigned depth);
        return $clog2(width + depth + 1);
    endfunction

endpackage

// File: rtl/siso_chain.sv
// DEPTH-stage enabled serial shift chain with asynchronous clear.
module siso_chain #(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] stages;

    // New bit enters stage 0; the cast keeps the shift legal for DEPTH=1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stages <= '0;
        end else if (en) begin
            stages <= DEPTH'({stages, din});
        end
    end

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/siso_frame_ctrl.sv
// Word serializer/deserializer sequencing a serial shift chain, LSB first.
module siso_frame_ctrl
    import siso_frame_pkg::*;
#(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned INTERNAL_CHAIN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sr_din,
    output logic             sr_en,
    input  logic             sr_dout,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int unsigned CNT_W = cnt_width(WIDTH, DEPTH);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_EDGE  = CNT_W'(WIDTH + DEPTH - 1);
    localparam logic [CNT_W-1:0] CAP_START  = CNT_W'(DEPTH);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [WIDTH-1:0] word_reg, word_d;
    logic [WIDTH-1:0] out_data_d;
    logic             sr_en_d, sr_din_d, in_ready_d, out_valid_d, busy_d;
    logic             chain_dout;

    // Next state, datapath and registered Moore outputs derived from next state.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        word_d     = word_reg;
        out_data_d = out_data;

        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    word_d  = in_data;
                end
            end
            SHIFT: begin
                cnt_d  = cnt + CNT_W'(1);
                word_d = word_reg >> 1;
                if (cnt >= CAP_START) begin
                    out_data_d = WIDTH'({chain_dout, out_data} >> 1);
                end
                if (cnt == LAST_SHIFT) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                cnt_d = cnt + CNT_W'(1);
                if (cnt >= CAP_START) begin
                    out_data_d = WIDTH'({chain_dout, out_data} >> 1);
                end
                if (cnt == LAST_EDGE) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
        endcase

        // word_reg is consumed from bit 0, so its LSB is always the next bit to send.
        sr_en_d     = (state_d == SHIFT) || (state_d == FLUSH);
        sr_din_d    = (state_d == SHIFT) && word_d[0];
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            word_reg  <= '0;
            out_data  <= '0;
            sr_en     <= 1'b0;
            sr_din    <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            word_reg  <= word_d;
            out_data  <= out_data_d;
            sr_en     <= sr_en_d;
            sr_din    <= sr_din_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            busy      <= busy_d;
        end
    end

    // Internal chain for self-contained use; otherwise capture from the external chain.
    if (INTERNAL_CHAIN != 0) begin : g_int_chain
        logic unused_sr_dout;
        assign unused_sr_dout = sr_dout;

        siso_chain #(.DEPTH(DEPTH)) u_chain (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (sr_en),
            .din  (sr_din),
            .dout (chain_dout)
        );
    end else begin : g_ext_chain
        assign chain_dout = sr_dout;
    end

endmodule
